// File: rtl/rgf_wb_ctrl.sv
// rgf_wb_ctrl: write-back arbiter and busy-register scoreboard for the
// 32x32 register file. The ALU and the LSU compete for the single RGF
// write port. ALU wins a collision unless the LSU has waited STARVE_LIMIT
// cycles. Registers with an outstanding write are tracked so that decode
// can stall on RAW/WAW hazards.
module rgf_wb_ctrl #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            chk_valid,
  input  logic [4:0]      chk_rs1,
  input  logic [4:0]      chk_rs2,
  input  logic [4:0]      chk_rd,
  output logic            stall,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic            alu_valid,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rgf_we,
  output logic [4:0]      rgf_wn,
  output logic [XLEN-1:0] rgf_data,
  output logic [31:0]     busy_vec
);

  localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);
  localparam logic [3:0] CNT_MAX = 4'd15;

  logic [31:0]     busy;
  logic [31:0]     busy_next;
  logic [3:0]      wait_cnt;
  logic            lsu_priority;
  logic            wb_grant;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;

  // Bit 0 is never set, so x0 can never produce a stall.
  assign busy_vec = busy;

  // Hazard check of the instruction currently sitting in decode.
  always_comb begin
    stall = chk_valid & (busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd]);
  end

  // Arbitration: one grant per cycle; a starving LSU overrides the ALU.
  always_comb begin
    lsu_priority = (wait_cnt >= LIMIT);
    alu_ready    = 1'b0;
    lsu_ready    = 1'b0;
    wb_grant     = 1'b0;
    wb_rd        = alu_rd;
    wb_data      = alu_data;
    if (lsu_valid && (!alu_valid || lsu_priority)) begin
      lsu_ready = 1'b1;
      wb_grant  = 1'b1;
      wb_rd     = lsu_rd;
      wb_data   = lsu_data;
    end else if (alu_valid) begin
      alu_ready = 1'b1;
      wb_grant  = 1'b1;
    end
  end

  // Next scoreboard: the write leaving the port clears, a new issue sets
  // (applied last so it wins over a clear of the same register).
  always_comb begin
    busy_next = busy;
    if (rgf_we && (rgf_wn != 5'd0)) begin
      busy_next[rgf_wn] = 1'b0;
    end
    if (issue_valid && (issue_rd != 5'd0)) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // LSU wait counter: counts consecutive refused LSU requests, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= 4'd0;
    end else if (!lsu_valid || lsu_ready) begin
      wait_cnt <= 4'd0;
    end else if (wait_cnt != CNT_MAX) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Registered RGF write port; x0 grants complete but never write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgf_we   <= 1'b0;
      rgf_wn   <= 5'd0;
      rgf_data <= '0;
    end else if (wb_grant) begin
      rgf_we   <= (wb_rd != 5'd0);
      rgf_wn   <= wb_rd;
      rgf_data <= wb_data;
    end else begin
      rgf_we   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rgf_wb_ctrl.sv
// tb_rgf_wb_ctrl: directed scenarios followed by random traffic. The
// stimulus side predicts each cycle's outputs from a behavioural model and
// queues them; a monitor on the falling edge pops and compares.
module tb_rgf_wb_ctrl;

  localparam int XLEN         = 32;
  localparam int STARVE_LIMIT = 4;

  logic            clk;
  logic            rst;
  logic            chk_valid;
  logic [4:0]      chk_rs1;
  logic [4:0]      chk_rs2;
  logic [4:0]      chk_rd;
  logic            stall;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            rgf_we;
  logic [4:0]      rgf_wn;
  logic [XLEN-1:0] rgf_data;
  logic [31:0]     busy_vec;

  rgf_wb_ctrl #(.XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .chk_valid(chk_valid), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .stall(stall),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rgf_we(rgf_we), .rgf_wn(rgf_wn), .rgf_data(rgf_data),
    .busy_vec(busy_vec)
  );

  typedef struct {
    bit        rst;
    bit        cv;
    bit [4:0]  rs1;
    bit [4:0]  rs2;
    bit [4:0]  rd;
    bit        iv;
    bit [4:0]  ird;
    bit        av;
    bit [4:0]  ard;
    bit [31:0] adata;
    bit        lv;
    bit [4:0]  lrd;
    bit [31:0] ldata;
  } stim_t;

  typedef struct {
    logic        stall;
    logic        ar;
    logic        lr;
    logic        we;
    logic [4:0]  wn;
    logic [31:0] data;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: which registers are awaiting a write, how long the
  // LSU has been refused, and what the write port shows this cycle.
  bit        m_busy[32];
  int        m_wait;
  bit        m_we;
  int        m_wn;
  bit [31:0] m_data;
  bit        g_alu;
  bit        g_lsu;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic bit modelStall(input stim_t s);
    return s.cv && (m_busy[s.rs1] || m_busy[s.rs2] || m_busy[s.rd]);
  endfunction

  task automatic resetModel();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_wait = 0;
    m_we   = 1'b0;
    m_wn   = 0;
    m_data = '0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // One clock cycle: drive, queue the predicted outputs, advance the model.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   lsu_wins;
    rst         = s.rst;
    chk_valid   = s.cv;
    chk_rs1     = s.rs1;
    chk_rs2     = s.rs2;
    chk_rd      = s.rd;
    issue_valid = s.iv;
    issue_rd    = s.ird;
    alu_valid   = s.av;
    alu_rd      = s.ard;
    alu_data    = s.adata;
    lsu_valid   = s.lv;
    lsu_rd      = s.lrd;
    lsu_data    = s.ldata;
    lsu_wins = s.lv && (!s.av || (m_wait >= STARVE_LIMIT));
    g_lsu = !s.rst && lsu_wins;
    g_alu = !s.rst && s.av && !lsu_wins;
    if (!s.rst) begin
      e.stall = modelStall(s);
      e.ar    = s.av && !lsu_wins;
      e.lr    = lsu_wins;
      e.we    = m_we;
      e.wn    = 5'(m_wn);
      e.data  = m_data;
      for (int i = 0; i < 32; i++) e.busy[i] = m_busy[i];
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (s.rst) begin
      resetModel();
    end else begin
      if (m_we && m_wn != 0) m_busy[m_wn] = 1'b0;
      if (s.iv && s.ird != 0) m_busy[s.ird] = 1'b1;
      if (!s.lv || g_lsu) m_wait = 0;
      else if (m_wait < 15) m_wait = m_wait + 1;
      if (g_alu) begin
        m_we = (s.ard != 0); m_wn = s.ard; m_data = s.adata;
      end else if (g_lsu) begin
        m_we = (s.lrd != 0); m_wn = s.lrd; m_data = s.ldata;
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("stall",     {31'd0, stall},     {31'd0, e.stall});
      checkOutput("alu_ready", {31'd0, alu_ready}, {31'd0, e.ar});
      checkOutput("lsu_ready", {31'd0, lsu_ready}, {31'd0, e.lr});
      checkOutput("rgf_we",    {31'd0, rgf_we},    {31'd0, e.we});
      checkOutput("rgf_wn",    {27'd0, rgf_wn},    {27'd0, e.wn});
      checkOutput("rgf_data",  rgf_data,           e.data);
      checkOutput("busy_vec",  busy_vec,           e.busy);
    end
  end

  initial begin
    stim_t     s;
    bit        a_pend, l_pend;
    bit [4:0]  a_rd, l_rd;
    bit [31:0] a_data, l_data;

    resetModel();
    s = idleStim();
    s.rst = 1'b1;
    applyStimulus(s);
    @(posedge clk); #1;

    // Reset held two cycles with both requesters active.
    s = idleStim(); s.rst = 1; s.av = 1; s.ard = 5'd1; s.lv = 1; s.lrd = 5'd2;
    applyStimulus(s);
    applyStimulus(s);
    s.rst = 0;
    applyStimulus(s);
    s = idleStim(); s.lv = 1; s.lrd = 5'd2;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());

    // RAW hazard on x5, resolved by an ALU write-back.
    s = idleStim(); s.cv = 1; s.rd = 5'd5; s.iv = 1; s.ird = 5'd5;
    applyStimulus(s);
    s = idleStim(); s.cv = 1; s.rs1 = 5'd5;
    applyStimulus(s);
    applyStimulus(s);
    s.av = 1; s.ard = 5'd5; s.adata = 32'h0000_1234;
    applyStimulus(s);
    s.av = 0;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idleStim());

    // Collision: ALU first, LSU next cycle.
    s = idleStim(); s.av = 1; s.ard = 5'd3; s.adata = 32'hAAAA_0003;
    s.lv = 1; s.lrd = 5'd7; s.ldata = 32'h5555_0007;
    applyStimulus(s);
    s.av = 0;
    applyStimulus(s);
    applyStimulus(idleStim());
    applyStimulus(idleStim());

    // Starvation: ALU busy every cycle, LSU waits until the limit.
    for (int c = 0; c < 8; c++) begin
      s = idleStim();
      s.av = 1; s.ard = 5'(c + 10); s.adata = 32'hC0DE_0000 + 32'(c);
      s.lv = (c <= STARVE_LIMIT); s.lrd = 5'd20; s.ldata = 32'hBEEF_0020;
      applyStimulus(s);
    end
    applyStimulus(idleStim());

    // x0 issue and write-back: handshake completes, nothing is written.
    s = idleStim(); s.cv = 1; s.iv = 1; s.ird = 5'd0;
    applyStimulus(s);
    s = idleStim(); s.cv = 1; s.av = 1; s.ard = 5'd0; s.adata = 32'hFFFF_FFFF;
    applyStimulus(s);
    s = idleStim(); s.cv = 1;
    applyStimulus(s);
    applyStimulus(s);

    // Set and clear of x9 on the same edge: the set survives.
    s = idleStim(); s.iv = 1; s.ird = 5'd9;
    applyStimulus(s);
    s = idleStim(); s.av = 1; s.ard = 5'd9; s.adata = 32'h0000_0909;
    applyStimulus(s);
    s = idleStim(); s.iv = 1; s.ird = 5'd9;
    applyStimulus(s);
    s = idleStim(); s.cv = 1; s.rs2 = 5'd9;
    applyStimulus(s);
    applyStimulus(s);

    // Random traffic with requesters that hold until granted.
    a_pend = 0; l_pend = 0;
    a_rd = 0; l_rd = 0; a_data = 0; l_data = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!a_pend && $urandom_range(0, 2) != 0) begin
        a_pend = 1; a_rd = 5'($urandom); a_data = $urandom;
      end
      if (!l_pend && $urandom_range(0, 2) != 0) begin
        l_pend = 1; l_rd = 5'($urandom); l_data = $urandom;
      end
      s = idleStim();
      s.rst = ($urandom_range(0, 299) == 0);
      s.cv  = $urandom_range(0, 1) != 0;
      s.rs1 = 5'($urandom); s.rs2 = 5'($urandom); s.rd = 5'($urandom);
      s.iv  = s.cv && !modelStall(s) && ($urandom_range(0, 1) != 0);
      s.ird = s.rd;
      s.av = a_pend; s.ard = a_rd; s.adata = a_data;
      s.lv = l_pend; s.lrd = l_rd; s.ldata = l_data;
      applyStimulus(s);
      if (g_alu) a_pend = 0;
      if (g_lsu) l_pend = 0;
    end

    applyStimulus(idleStim());
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
